multicycle_control: RTL and testbench

Multicycle control FSM that sequences the single-memory CPU datapath: instruction fetch, decode, execute, memory access and write-back across several cycles per instruction. It sits beside the `execution` datapath, consumes the instruction register fields, ALU `zero` and a memory ready handshake, and drives every datapath select and write-enable. It supports the Lab3 instruction set: LW, SW, J, JAL, JR, BEQ, BNE, XORI, ADDI, ADD, SUB and SLT.

---
 rtl/multicycle_control_pkg.sv | 50 +++++
 rtl/instr_decode.sv | 51 +++++
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM.
// The ALU op and opcode/funct constants are shared with the datapath ALU.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    C_LW, C_SW, C_R, C_JR, C_I,
    C_BEQ, C_BNE, C_J, C_JAL, C_ILL
  } iclass_e;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_HALT      = 4'd14
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/funct classifier.
// Gives instruction class, ALU op for R/I types and an illegal flag.
module instr_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    cls,
  output alu_op_e    alu_op,
  output logic       imm_zext,
  output logic       illegal
);

  logic is_r;

  assign is_r = (opcode == OP_RTYPE);

  always_comb begin
    cls      = C_ILL;
    alu_op   = ALU_ADD;
    imm_zext = 1'b0;
    unique case (1'b1)
      (opcode == OP_LW):   cls = C_LW;
      (opcode == OP_SW):   cls = C_SW;
      (is_r && funct == FN_ADD): cls = C_R;
      (is_r && funct == FN_SUB): begin
        cls    = C_R;
        alu_op = ALU_SUB;
      end
      (is_r && funct == FN_SLT): begin
        cls    = C_R;
        alu_op = ALU_SLT;
      end
      (is_r && funct == FN_JR): cls = C_JR;
      (opcode == OP_ADDI): cls = C_I;
      (opcode == OP_XORI): begin
        cls      = C_I;
        alu_op   = ALU_XOR;
        imm_zext = 1'b1;
      end
      (opcode == OP_BEQ):  cls = C_BEQ;
      (opcode == OP_BNE):  cls = C_BNE;
      (opcode == OP_J):    cls = C_J;
      (opcode == OP_JAL):  cls = C_JAL;
      default:             cls = C_ILL;
    endcase
  end

  assign illegal = (cls == C_ILL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the single-memory CPU datapath.
// Outputs are state decodes, forced to zero while reset is held.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [2:0]         alu_op,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count,
  output logic               error
);

  state_e  state, state_nxt;
  iclass_e cls;
  alu_op_e dec_alu_op;
  logic    dec_zext;
  logic    dec_illegal;

  instr_decode u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .cls      (cls),
    .alu_op   (dec_alu_op),
    .imm_zext (dec_zext),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (instr_done)
        instr_count <= instr_count + COUNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    imm_zext   = 1'b0;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    instr_done = 1'b0;
    error      = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        unique case (cls)
          C_LW, C_SW:   state_nxt = S_MEM_ADDR;
          C_R:          state_nxt = S_R_EXEC;
          C_JR:         state_nxt = S_JR;
          C_I:          state_nxt = S_I_EXEC;
          C_BEQ, C_BNE: state_nxt = S_BRANCH;
          C_J:          state_nxt = S_JUMP;
          C_JAL:        state_nxt = S_JAL;
          default:      state_nxt = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nxt = (cls == C_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_we     = 1'b1;
        reg_dst    = 2'd1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = dec_alu_op;
        imm_zext  = dec_zext;
        state_nxt = S_I_WB;
      end
      S_I_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        pc_we      = (cls == C_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        pc_we      = 1'b1;
        pc_src     = 2'd2;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JAL: begin
        pc_we      = 1'b1;
        pc_src     = 2'd2;
        reg_we     = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JR: begin
        pc_we      = 1'b1;
        pc_src     = 2'd3;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_HALT: begin
        error = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
    // FETCH is the reset state but must not request memory until release
    if (!reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      imm_zext   = 1'b0;
      alu_op     = ALU_ADD;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      instr_done = 1'b0;
      error      = 1'b0;
    end
  end

  logic unused_illegal;
  assign unused_illegal = dec_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// A second 2-bit-counter instance covers counter wrap.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic        alu_src_a, imm_zext, reg_we, instr_done, error;
  logic [2:0]  alu_op;
  logic [31:0] instr_count;

  logic        w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we;
  logic [1:0]  w_pc_src, w_alu_src_b, w_reg_dst, w_mem_to_reg;
  logic        w_alu_src_a, w_imm_zext, w_reg_we, w_done, w_error;
  logic [2:0]  w_alu_op;
  logic [1:0]  w_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .alu_op(alu_op), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .instr_count(instr_count),
    .error(error)
  );

  multicycle_control #(.COUNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .iord(w_iord),
    .ir_we(w_ir_we), .pc_we(w_pc_we), .pc_src(w_pc_src),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
    .imm_zext(w_imm_zext), .alu_op(w_alu_op), .reg_we(w_reg_we),
    .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .instr_done(w_done), .instr_count(w_count),
    .error(w_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; opcode = 6'h00; funct = 6'h00;
    zero = 1'b0; mem_ready = 1'b1;
    nxt(); nxt();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_alu_b", alu_src_b, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_error", error, 0);

    // LW, zero-wait: 5 cycles
    opcode = 6'h23;
    reset = 1'b1; #1;
    chk("lw_c1_req", mem_req, 1);
    chk("lw_c1_ir", ir_we, 1);
    chk("lw_c1_pc", pc_we, 1);
    chk("lw_c1_b", alu_src_b, 1);
    chk("lw_c1_rwe", reg_we, 0);
    nxt();
    chk("lw_c2_b", alu_src_b, 3);
    chk("lw_c2_req", mem_req, 0);
    chk("lw_c2_rwe", reg_we, 0);
    nxt();
    chk("lw_c3_a", alu_src_a, 1);
    chk("lw_c3_b", alu_src_b, 2);
    chk("lw_c3_rwe", reg_we, 0);
    nxt();
    chk("lw_c4_req", mem_req, 1);
    chk("lw_c4_iord", iord, 1);
    chk("lw_c4_we", mem_we, 0);
    chk("lw_c4_rwe", reg_we, 0);
    nxt();
    chk("lw_c5_rwe", reg_we, 1);
    chk("lw_c5_m2r", mem_to_reg, 1);
    chk("lw_c5_dst", reg_dst, 0);
    chk("lw_c5_done", instr_done, 1);
    chk("lw_c5_cnt", instr_count, 0);
    nxt();
    chk("lw_cnt", instr_count, 1);

    // ADD with 3 wait cycles in FETCH
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("add_wait_req", mem_req, 1);
      chk("add_wait_ir", ir_we, 0);
      chk("add_wait_pc", pc_we, 0);
      nxt();
    end
    mem_ready = 1'b1; #1;
    chk("add_f_req", mem_req, 1);
    chk("add_f_ir", ir_we, 1);
    chk("add_f_pc", pc_we, 1);
    nxt();
    chk("add_dec_b", alu_src_b, 3);
    nxt();
    chk("add_ex_a", alu_src_a, 1);
    chk("add_ex_b", alu_src_b, 0);
    chk("add_ex_op", alu_op, 0);
    nxt();
    chk("add_wb_rwe", reg_we, 1);
    chk("add_wb_dst", reg_dst, 1);
    chk("add_wb_m2r", mem_to_reg, 0);
    chk("add_wb_op", alu_op, 0);
    chk("add_wb_done", instr_done, 1);
    nxt();
    chk("add_cnt", instr_count, 2);

    // SLT opcode 0 funct 0x2a
    funct = 6'h2a;
    nxt(); nxt();
    chk("slt_ex_op", alu_op, 3);
    nxt(); nxt();
    chk("slt_cnt", instr_count, 3);

    // BEQ/BNE with zero=1/0
    opcode = 6'h04; zero = 1'b1;
    nxt(); nxt();
    chk("beq1_pc_we", pc_we, 1);
    chk("beq1_pc_src", pc_src, 1);
    chk("beq1_op", alu_op, 1);
    chk("beq1_done", instr_done, 1);
    nxt();
    zero = 1'b0;
    nxt(); nxt();
    chk("beq0_pc_we", pc_we, 0);
    chk("beq0_done", instr_done, 1);
    nxt();
    opcode = 6'h05; zero = 1'b1;
    nxt(); nxt();
    chk("bne1_pc_we", pc_we, 0);
    nxt();
    zero = 1'b0;
    nxt(); nxt();
    chk("bne0_pc_we", pc_we, 1);
    chk("bne0_pc_src", pc_src, 1);
    nxt();
    chk("br_cnt", instr_count, 7);

    // JAL
    opcode = 6'h03;
    nxt(); nxt();
    chk("jal_pc_we", pc_we, 1);
    chk("jal_pc_src", pc_src, 2);
    chk("jal_rwe", reg_we, 1);
    chk("jal_dst", reg_dst, 2);
    chk("jal_m2r", mem_to_reg, 2);
    nxt();
    chk("jal_cnt", instr_count, 8);

    // JR: opcode 0 funct 0x08
    opcode = 6'h00; funct = 6'h08;
    nxt(); nxt();
    chk("jr_pc_src", pc_src, 3);
    chk("jr_pc_we", pc_we, 1);
    nxt();

    // XORI
    opcode = 6'h0e;
    nxt(); nxt();
    chk("xori_op", alu_op, 2);
    chk("xori_zext", imm_zext, 1);
    chk("xori_b", alu_src_b, 2);
    nxt();
    chk("xori_rwe", reg_we, 1);
    chk("xori_dst", reg_dst, 0);
    nxt();
    chk("xori_cnt", instr_count, 10);

    // SW with one wait in MEM_WRITE
    opcode = 6'h2b;
    nxt(); nxt(); nxt();
    mem_ready = 1'b0; #1;
    chk("sw_w_we", mem_we, 1);
    chk("sw_w_iord", iord, 1);
    chk("sw_w_done", instr_done, 0);
    nxt();
    mem_ready = 1'b1; #1;
    chk("sw_done", instr_done, 1);
    chk("sw_rwe", reg_we, 0);
    nxt();
    chk("sw_cnt", instr_count, 11);
    chk("wrap_cnt", w_count, 3);

    // One more ADDI to wrap the 2-bit counter
    opcode = 6'h08;
    nxt(); nxt();
    chk("addi_zext", imm_zext, 0);
    chk("addi_op", alu_op, 0);
    nxt(); nxt();
    chk("wrap_zero", w_count, 0);
    chk("addi_cnt", instr_count, 12);

    // Illegal opcode -> HALT
    opcode = 6'h3f;
    nxt(); nxt();
    for (int i = 0; i < 20; i++) begin
      chk("halt_err", error, 1);
      chk("halt_req", mem_req, 0);
      chk("halt_cnt", instr_count, 12);
      nxt();
    end
    reset = 1'b0; #1;
    chk("halt_rst_err", error, 0);
    chk("halt_rst_cnt", instr_count, 0);
    nxt();

    // Reset during MEM_READ wait
    opcode = 6'h23;
    reset = 1'b1;
    nxt(); nxt(); nxt();
    mem_ready = 1'b0; #1;
    chk("mr_req", mem_req, 1);
    chk("mr_iord", iord, 1);
    reset = 1'b0; #1;
    chk("mr_rst_req", mem_req, 0);
    chk("mr_rst_iord", iord, 0);
    chk("mr_rst_cnt", instr_count, 0);
    nxt();
    reset = 1'b1; mem_ready = 1'b1; #1;
    chk("mr_fetch_req", mem_req, 1);
    chk("mr_fetch_ir", ir_we, 1);
    chk("mr_fetch_iord", iord, 0);
    nxt(); nxt(); nxt(); nxt();
    chk("mr_lw_done", instr_done, 1);
    nxt();
    chk("mr_cnt", instr_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
